useq_sequencer: RTL
===================

# useq_sequencer

Microprogram sequencer for the control unit: it holds the micro-program counter, drives the 8-bit address of the 256 x 64 control ROM, and picks the next microinstruction address from the ROM's next-state, condition-select, invert and CR fields. It also provides an 8-bit loop counter and a 4-deep micro-subroutine return stack. It sits between the instruction decoder, the status/flag logic and the control ROM, and advances one microinstruction per clock.

## Interface
- AW, 8, micro-address width; fixed by the 256-entry ROM.
- DEPTH, 4, return-stack entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- hold  in  1  stall; all state frozen while high.
- n_sel  in  3  ROM next-state field N2-N0.
- inv  in  1  ROM INV bit; inverts the selected condition.
- s_sel  in  3  ROM condition-select field S2-S0.
- cr  in  16  ROM CR15-CR0; cr[7:0] is the primary target, cr[15:8] the alternate target or counter preload.
- load_cnt  in  1  ROM LoadCNT bit.
- cond  in  8  status conditions (MOC, flags, decoder-valid, ...); cond[0] is ignored and treated as 1.
- dec_addr  in  AW  dispatch address from the instruction decoder.
- uaddr  out  AW  registered micro-PC, drives the ROM address.
- cnt  out  8  loop counter value.
- sp  out  3  stack occupancy, 0..DEPTH.
- stk_err  out  1  sticky stack overflow/underflow flag.

## Operation
- Let c = (s_sel==0 ? 1 : cond[s_sel]) ^ inv, and inc = uaddr+1 modulo 256 (8'hFF wraps to 8'h00).
- Next address by n_sel:
  - 000 INC: inc.
  - 001 JMP: cr[7:0].
  - 010 DISP: dec_addr.
  - 011 CBR: c ? cr[7:0] : inc.
  - 100 CSEL: c ? cr[7:0] : cr[15:8].
  - 101 CALL: push inc, then go to cr[7:0].
  - 110 RET: pop, then go to the popped value.
  - 111 LOOP: if cnt!=0, decrement cnt and go to cr[7:0]; if cnt==0, go to inc with cnt unchanged.
- Wait states are coded as CBR to the current address (for example spin on !MOC).
- Counter:
  - load_cnt=1 loads cnt <= cr[15:8] in every mode except LOOP.
  - In LOOP, load_cnt is ignored.
- Stack: a LIFO of DEPTH entries; sp counts valid entries.
  - CALL with sp==DEPTH: push is dropped, stk_err is set, the jump still happens, sp stays at DEPTH.
  - RET with sp==0: next address is 8'h00 (fetch), stk_err is set, sp stays at 0.
- stk_err clears only on reset.
- When hold is high, uaddr, cnt, the stack, sp and stk_err all keep their values, and load_cnt is ignored.
- Reset mid-operation clears everything immediately, whatever the pending control word.

## Timing
- Reset values (asynchronous): uaddr=8'h00, cnt=8'h00, sp=0, stk_err=0. Stack contents are don't-care.
- One microinstruction per cycle. The ROM is combinational on uaddr, and all inputs are sampled at the rising edge in the same cycle that uaddr presents the word.
- The next uaddr, cnt, sp and stk_err all update on that one edge; no extra latency.
- cond and dec_addr must be stable before the edge; there is no internal synchronization.
- Deassertion of rst_n is assumed synchronous to clk externally. The first edge after deassertion executes address 8'h00.
- hold takes effect on the edge at which it is sampled high; execution resumes on the first edge with hold low.

## Test plan
- Reset/INC: pulse rst_n low mid-run at uaddr=8'h37 -> uaddr=0 immediately. Then INC words give 1,2,3. From uaddr=8'hFF, INC -> 8'h00.
- CBR wait: s_sel=1 (MOC), inv=1, cr[7:0]=8'h12 at uaddr 8'h12; hold cond[1]=0 for 3 cycles -> uaddr stays 8'h12. When cond[1]=1 -> 8'h13.
- DISP/CSEL: dec_addr=8'hC9 with n_sel=010 -> uaddr=8'hC9. CSEL with cr=16'h1F40: c=1 gives 8'h40, c=0 gives 8'h1F.
- LOOP: load_cnt with cr[15:8]=3, then LOOP to 8'h50 from 8'h51 -> body runs 3 extra times (cnt 3->2->1->0), then uaddr=8'h52 with cnt=0. load_cnt asserted during LOOP does not change cnt.
- Nested CALL/RET: calls at 8'h10, 8'h20, 8'h30, 8'h40 -> sp=4. A fifth CALL -> stk_err=1, sp=4. Four RETs return to 8'h41, 8'h31, 8'h21, 8'h11. A fifth RET -> uaddr=0, sp=0.
- hold: assert hold for 2 cycles during a LOOP with cnt=2 -> uaddr, cnt and sp unchanged; the loop resumes correctly afterwards.

Source files
------------

// File: rtl/useq_sequencer_if.sv
// Bundle between the control ROM / decoder / flag logic and the microprogram sequencer.
interface useq_sequencer_if #(
    parameter int unsigned AW = 8
);
    logic          hold;
    logic [2:0]    n_sel;
    logic          inv;
    logic [2:0]    s_sel;
    logic [15:0]   cr;
    logic          load_cnt;
    logic [7:0]    cond;
    logic [AW-1:0] dec_addr;
    logic [AW-1:0] uaddr;
    logic [7:0]    cnt;
    logic [2:0]    sp;
    logic          stk_err;

    // Driver side: ROM word, conditions and decoder address in, sequencer state out.
    modport master (
        output hold, n_sel, inv, s_sel, cr, load_cnt, cond, dec_addr,
        input  uaddr, cnt, sp, stk_err
    );

    // Sequencer side.
    modport slave (
        input  hold, n_sel, inv, s_sel, cr, load_cnt, cond, dec_addr,
        output uaddr, cnt, sp, stk_err
    );
endinterface

// File: rtl/useq_sequencer.sv
// Microprogram sequencer: micro-PC, next-address select, loop counter and
// a small return stack for micro-subroutines. One microinstruction per clock.
module useq_sequencer #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic             clk,
    input logic             rst_n,
    useq_sequencer_if.slave bus
);
    localparam int unsigned SW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0]  SP_FULL = 3'(DEPTH);

    typedef enum logic [2:0] {
        NInc  = 3'd0,
        NJmp  = 3'd1,
        NDisp = 3'd2,
        NCbr  = 3'd3,
        NCsel = 3'd4,
        NCall = 3'd5,
        NRet  = 3'd6,
        NLoop = 3'd7
    } next_e;

    logic [AW-1:0] uaddr_q, uaddr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [2:0]    sp_q, sp_d;
    logic          err_q, err_d;
    logic [AW-1:0] stack_q [DEPTH];

    next_e         next_sel;
    logic          c;
    logic [AW-1:0] inc;
    logic [AW-1:0] tgt;
    logic [AW-1:0] alt;
    logic          push_en;
    logic [SW-1:0] push_idx;
    logic [SW-1:0] pop_idx;

    assign next_sel = next_e'(bus.n_sel);
    assign inc      = uaddr_q + AW'(1);
    assign tgt      = AW'(bus.cr[7:0]);
    assign alt      = AW'(bus.cr[15:8]);
    assign push_idx = sp_q[SW-1:0];
    assign pop_idx  = SW'(sp_q - 3'd1);

    // Next-state selection; hold freezes everything including counter preload.
    always_comb begin
        uaddr_d = uaddr_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        // Condition 0 is hard-wired true, so s_sel=0 gives an unconditional select.
        c = ((bus.s_sel == 3'd0) ? 1'b1 : bus.cond[bus.s_sel]) ^ bus.inv;
        if (!bus.hold) begin
            if (bus.load_cnt && next_sel != NLoop) begin
                cnt_d = bus.cr[15:8];
            end
            unique case (next_sel)
                NInc:  uaddr_d = inc;
                NJmp:  uaddr_d = tgt;
                NDisp: uaddr_d = bus.dec_addr;
                NCbr:  uaddr_d = c ? tgt : inc;
                NCsel: uaddr_d = c ? tgt : alt;
                NCall: begin
                    uaddr_d = tgt;
                    if (sp_q == SP_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + 3'd1;
                    end
                end
                NRet: begin
                    if (sp_q == 3'd0) begin
                        // Underflow falls back to the fetch routine at address 0.
                        uaddr_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        uaddr_d = stack_q[pop_idx];
                        sp_d    = sp_q - 3'd1;
                    end
                end
                NLoop: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d   = cnt_q - 8'd1;
                        uaddr_d = tgt;
                    end else begin
                        uaddr_d = inc;
                    end
                end
                default: uaddr_d = inc;
            endcase
        end
    end

    // Sequencer state registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            uaddr_q <= '0;
            cnt_q   <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            uaddr_q <= uaddr_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Return-stack storage; contents are meaningless after reset so no clear.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[push_idx] <= inc;
        end
    end

    assign bus.uaddr   = uaddr_q;
    assign bus.cnt     = cnt_q;
    assign bus.sp      = sp_q;
    assign bus.stk_err = err_q;
endmodule
